pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
- Receive-side counterpart of the PWM output array: measures the duty cycle of STAGE PWM lines over fixed 2^DWIDTH-cycle periods.
- Recovers one DWIDTH-bit data word per line and streams the words out serially over a valid/ready handshake, channel 0 first.
- Used in loopback self-test and for decoding externally generated PWM frames back into data words.

Parameters:
- DWIDTH, 8, data word width; PWM period = 2^DWIDTH clk cycles.
- STAGE, 8, number of PWM input channels (words per frame).

Ports:
- clk  input  1  sampling clock; the same rate as the PWM generator's counter clock.
- rst  input  1  asynchronous, active-low reset.
- sync  input  1  one-cycle pulse marking the first cycle of a PWM period.
- pwm_in  input  STAGE  PWM lines; bit i is channel i.
- out_data  output  DWIDTH  recovered word for the current channel.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts the word when out_valid && out_ready.
- out_last  output  1  high with the word of channel STAGE-1.
- overrun  output  1  one-cycle pulse: a completed frame was dropped.

Behaviour:
- Reset (rst=0, async): all outputs 0; pcnt=0; all hcnt=0; armed=0; FSM=IDLE; idx=0.
- Period counter pcnt, DWIDTH bits:
  - sync=1: pcnt<=1, armed<=1.
  - Otherwise: pcnt<=pcnt+1, wrapping at 2^DWIDTH.
- The sync cycle is period cycle 0.
- High counters hcnt[i], DWIDTH+1 bits:
  - sync=1: hcnt[i]<=pwm_in[i].
  - Otherwise: hcnt[i]<=hcnt[i]+pwm_in[i].
- Period completion:
  - The cycle with pcnt==2^DWIDTH-1, armed=1 and sync=0 is the last sampled cycle.
  - Result word = min(hcnt[i]+pwm_in[i], 2^DWIDTH-1), saturating.
  - A generator word d therefore decodes to d; all-high decodes to 2^DWIDTH-1.
- Completion resets the counters exactly as sync would on the next cycle, via natural wrap: the next period starts at pcnt=0 with hcnt cleared.
- sync mid-period (pcnt != 0): the current partial period is discarded with no capture; counting restarts. sync coinciding with pcnt==2^DWIDTH-1 also discards.
- Before the first sync after reset (armed=0): nothing is captured.
- Output FSM, two states:
  - IDLE: out_valid=0. On completion, load all STAGE results into the shadow buffer, idx<=0, go to SEND.
  - SEND: out_valid=1, out_data=shadow[idx], out_last=(idx==STAGE-1). A handshake increments idx. A handshake at idx==STAGE-1 returns to IDLE.
- Latency: out_valid rises on the clk edge that samples the last cycle of the period. The first word is visible in the following cycle.
- out_data/out_valid/out_last are stable while out_valid && !out_ready.
- Completion while in SEND, not on the final handshake: the new frame is dropped, overrun pulses for 1 cycle, and the in-flight frame is unaffected.
- Completion in the same cycle as the final handshake (idx==STAGE-1): the new frame loads, the FSM stays in SEND, idx<=0, no overrun.
- Reset mid-transfer: the transfer is aborted immediately and the frame is lost. armed clears, so a new sync is required.

Test Plan (DWIDTH=4, STAGE=4, period 16 cycles):
- Reset, sync, then drive each channel high for its first d cycles (d = 3,0,15,8); out_ready=1 → out_valid rises 16 cycles after sync. out_data sequence 3,0,15,8; out_last only on the 4th word.
- Channel 1 held high for all 16 cycles → that word = 15 (saturated). Channel held low → 0.
- Back-pressure: out_ready=0 for 5 cycles after out_valid → word 0 held stable, then the sequence completes unchanged. Consumer stalls past the next period end → overrun pulses once, second frame dropped, first frame words intact.
- sync asserted at pcnt=7 of a period → no frame emitted for the partial period. The next full period (d=5,5,5,5) emits 5,5,5,5 exactly 16 cycles after that sync.
- No sync after reset, toggling pwm_in for 64 cycles → out_valid stays 0.
- rst pulled low while out_valid=1 at idx=2 → all outputs 0 immediately; no words until a new sync plus a full period.

Source files
------------

// File: rtl/pwm_capture.sv
// Recovers one DWIDTH-bit word per PWM line from the high-time in each 2^DWIDTH-cycle period.
// Each completed frame is streamed out word by word over valid/ready, channel 0 first.
module pwm_capture #(
  parameter int DWIDTH = 8,
  parameter int STAGE  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sync,
  input  logic [STAGE-1:0]  pwm_in,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              overrun
);

  localparam int IW = (STAGE > 1) ? $clog2(STAGE) : 1;
  localparam logic [DWIDTH-1:0] PMAX = {DWIDTH{1'b1}};
  localparam logic [IW-1:0] LAST_IDX = IW'(STAGE - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  logic [DWIDTH-1:0] pcnt_r;
  logic              armed_r;
  logic [DWIDTH:0]   hcnt_r   [STAGE];
  logic [DWIDTH-1:0] shadow_r [STAGE];
  logic [DWIDTH-1:0] result_s [STAGE];
  state_t            state_r;
  logic [IW-1:0]     idx_r;
  logic [IW-1:0]     next_idx_s;
  logic [DWIDTH-1:0] out_data_r;
  logic              out_valid_r;
  logic              out_last_r;
  logic              overrun_r;
  logic              complete_s;
  logic              handshake_s;
  logic              final_hs_s;
  logic              load_s;

  // A sum of 2^DWIDTH only occurs for an all-high line; clamp it to the top code.
  function automatic logic [DWIDTH-1:0] sat_word(input logic [DWIDTH:0] sum);
    return sum[DWIDTH] ? PMAX : sum[DWIDTH-1:0];
  endfunction

  // Period completion, handshake and saturated per-channel results.
  always_comb begin
    complete_s  = armed_r && !sync && (pcnt_r == PMAX);
    handshake_s = out_valid_r && out_ready;
    final_hs_s  = handshake_s && (idx_r == LAST_IDX);
    load_s      = complete_s && ((state_r == IDLE) || final_hs_s);
    next_idx_s  = idx_r + IW'(1);
    for (int i = 0; i < STAGE; i++) begin
      result_s[i] = sat_word(hcnt_r[i] + (DWIDTH + 1)'(pwm_in[i]));
    end
  end

  // Period and high-time counters; completion clears them so the next period starts cleanly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt_r  <= '0;
      armed_r <= 1'b0;
      for (int i = 0; i < STAGE; i++) hcnt_r[i] <= '0;
    end else if (sync) begin
      pcnt_r  <= DWIDTH'(1);
      armed_r <= 1'b1;
      for (int i = 0; i < STAGE; i++) hcnt_r[i] <= (DWIDTH + 1)'(pwm_in[i]);
    end else if (complete_s) begin
      pcnt_r <= '0;
      for (int i = 0; i < STAGE; i++) hcnt_r[i] <= '0;
    end else begin
      pcnt_r <= pcnt_r + DWIDTH'(1);
      for (int i = 0; i < STAGE; i++) hcnt_r[i] <= hcnt_r[i] + (DWIDTH + 1)'(pwm_in[i]);
    end
  end

  // Output FSM: shadow-buffers a frame and streams it; a frame finishing mid-stream is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      idx_r       <= '0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      overrun_r   <= 1'b0;
      for (int i = 0; i < STAGE; i++) shadow_r[i] <= '0;
    end else begin
      overrun_r <= complete_s && (state_r == SEND) && !final_hs_s;
      if (load_s) begin
        for (int i = 0; i < STAGE; i++) shadow_r[i] <= result_s[i];
        state_r     <= SEND;
        idx_r       <= '0;
        out_data_r  <= result_s[0];
        out_valid_r <= 1'b1;
        out_last_r  <= (STAGE == 1);
      end else begin
        case (state_r)
          IDLE: state_r <= IDLE;
          SEND: begin
            if (final_hs_s) begin
              state_r     <= IDLE;
              idx_r       <= '0;
              out_valid_r <= 1'b0;
              out_last_r  <= 1'b0;
            end else if (handshake_s) begin
              idx_r      <= next_idx_s;
              out_data_r <= shadow_r[next_idx_s];
              out_last_r <= (next_idx_s == LAST_IDX);
            end else begin
              idx_r <= idx_r;
            end
          end
          default: begin
            state_r     <= IDLE;
            idx_r       <= '0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_pwm_capture.sv
// Randomized bench for pwm_capture (DWIDTH=4, STAGE=4) against a frame-level reference model.
module tb_pwm_capture;

  localparam int DW   = 4;
  localparam int ST   = 4;
  localparam int PER  = 16;
  localparam int MAXW = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          sync;
  logic [ST-1:0] pwm_in;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          overrun;

  always #5 clk = ~clk;

  pwm_capture #(.DWIDTH(DW), .STAGE(ST)) dut (
    .clk      (clk),
    .rst      (rst),
    .sync     (sync),
    .pwm_in   (pwm_in),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .overrun  (overrun)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: period phase, per-channel high counts, words of the frame in flight.
  bit armed_m;
  int ph_m;
  int cnt_m [ST];
  bit busy_m;
  int q_m [$];
  bit ovr_m;
  int ready_mode;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    armed_m = 1'b0;
    ph_m    = 0;
    for (int i = 0; i < ST; i++) cnt_m[i] = 0;
    busy_m  = 1'b0;
    q_m.delete();
    ovr_m   = 1'b0;
  endtask

  // Called at a falling edge: compare outputs, drive next inputs, advance model one cycle.
  task automatic step(input bit s, input logic [ST-1:0] p);
    bit rdy, hs, last, done;
    int words [ST];
    check("valid", out_valid, busy_m);
    if (busy_m) check("data", out_data, q_m[0]);
    check("last", out_last, busy_m && (q_m.size() == 1));
    check("overrun", overrun, ovr_m);
    rdy = (ready_mode == 0) ? 1'b1 : (ready_mode == 2) ? 1'b0 : ($urandom_range(0, 2) != 0);
    sync = s;
    pwm_in = p;
    out_ready = rdy;
    hs   = busy_m && rdy;
    last = hs && (q_m.size() == 1);
    done = 1'b0;
    if (s) begin
      armed_m = 1'b1;
      ph_m = 1;
      for (int i = 0; i < ST; i++) cnt_m[i] = int'(p[i]);
    end else if (armed_m && ph_m == PER - 1) begin
      done = 1'b1;
      for (int i = 0; i < ST; i++) begin
        words[i] = cnt_m[i] + int'(p[i]);
        if (words[i] > MAXW) words[i] = MAXW;
        cnt_m[i] = 0;
      end
      ph_m = 0;
    end else begin
      ph_m = (ph_m + 1) % PER;
      for (int i = 0; i < ST; i++) cnt_m[i] += int'(p[i]);
    end
    if (hs) void'(q_m.pop_front());
    ovr_m = done && busy_m && !last;
    if (done && (!busy_m || last)) begin
      q_m.delete();
      for (int i = 0; i < ST; i++) q_m.push_back(words[i]);
    end
    busy_m = (q_m.size() != 0);
    @(negedge clk);
  endtask

  // Generator-style period: line i is high for its first d[i] cycles (d=16 means all-high).
  task automatic period(input int d [ST], input bit sync_first, input int len);
    logic [ST-1:0] p;
    for (int c = 0; c < len; c++) begin
      for (int i = 0; i < ST; i++) p[i] = (c < d[i]);
      step(sync_first && (c == 0), p);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    sync = 1'b0;
    pwm_in = '0;
    out_ready = 1'b0;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_last", out_last, 0);
    check("rst_overrun", overrun, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin : main
    bit reached;
    int d [ST];
    rst = 1'b0;
    sync = 1'b0;
    pwm_in = '0;
    out_ready = 1'b0;
    ready_mode = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // No sync yet: toggling lines must not produce a frame.
    ready_mode = 1;
    repeat (64) step(1'b0, ST'($urandom));

    ready_mode = 0;
    period('{3, 0, 15, 8}, 1'b1, PER);
    period('{0, 16, 0, 16}, 1'b0, PER);
    period('{1, 2, 3, 4}, 1'b0, PER);

    // Stall through a whole period so the next completion is dropped.
    ready_mode = 2;
    period('{7, 9, 11, 13}, 1'b0, PER);
    ready_mode = 0;
    period('{2, 2, 2, 2}, 1'b0, PER);

    // Short stall of five cycles, then drain.
    ready_mode = 2;
    period('{10, 4, 12, 1}, 1'b0, 5);
    ready_mode = 0;
    period('{10, 4, 12, 1}, 1'b0, PER - 5);

    // Partial period cut by a sync at phase 7.
    period('{6, 6, 6, 6}, 1'b0, 7);
    period('{5, 5, 5, 5}, 1'b1, PER);
    period('{0, 0, 0, 0}, 1'b0, PER);

    // Reset while word 2 of a frame is on the bus.
    period('{9, 3, 14, 0}, 1'b0, PER);
    reached = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (busy_m && q_m.size() == ST - 2) begin
        reached = 1'b1;
        break;
      end
      step(1'b0, ST'($urandom));
    end
    check("reach_idx2", reached, 1);
    do_reset();
    ready_mode = 1;
    repeat (40) step(1'b0, ST'($urandom));
    ready_mode = 0;
    period('{4, 8, 12, 16}, 1'b1, PER);
    period('{0, 0, 0, 0}, 1'b0, PER);

    // Random frames, random back-pressure, occasional truncated periods and resyncs.
    repeat (40) begin
      for (int i = 0; i < ST; i++) d[i] = $urandom_range(0, 16);
      ready_mode = ($urandom_range(0, 4) == 0) ? 2 : $urandom_range(0, 1);
      if ($urandom_range(0, 5) == 0) period(d, 1'b1, $urandom_range(1, 15));
      else period(d, ($urandom_range(0, 3) == 0), PER);
    end
    ready_mode = 0;
    period('{0, 0, 0, 0}, 1'b0, PER);
    period('{0, 0, 0, 0}, 1'b0, PER);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
